// File: rtl/apb_requester.sv
// apb_requester: APB (AMBA 3) requester.
// Turns single-beat valid/ready commands into APB SETUP/ACCESS transfers and
// returns read data / error status on a valid/ready response port.
// Only one transfer is in flight at a time. A programmable wait-state limit
// aborts transfers to a slave that holds pready low for too long.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   cmd_*           - command port (valid/ready, write, addr, wdata)
//   rsp_*           - response port (valid/ready, rdata, err, timeout)
//   busy            - a transfer is in progress (state != IDLE)
//   psel..pwdata    - APB requester outputs
//   prdata, pready,
//   pslverr         - APB completer inputs
module apb_requester #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16     // legal range 2..65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // A pending response blocks new commands so the response fields stay stable
    // until consumed. Gated by rst so nothing is accepted while in reset.
    assign cmd_ready = (state == IDLE) && !rsp_valid && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rsp_valid && rsp_ready)
                        rsp_valid <= 1'b0;
                    // cmd_ready already excludes a pending response, so the
                    // two branches never fire together.
                    if (cmd_valid && cmd_ready) begin
                        state    <= SETUP;
                        psel     <= 1'b1;
                        penable  <= 1'b0;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        pwrite   <= cmd_write;
                        paddr    <= cmd_addr;
                        pwdata   <= cmd_write ? cmd_wdata : '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready) begin
                        // Completion wins even on the cycle a timeout would fire.
                        state       <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        busy        <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                    end else if (wait_cnt == CNT_LAST) begin
                        state       <= IDLE;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        busy        <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    psel    <= 1'b0;
                    penable <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
